classificador_toque: RTL and testbench
======================================

CLASSIFICADOR_TOQUE -- requirements
Module: classificador_toque

Interface
REQ-001 Parameter LONG_TICKS, default 200, number of tick periods a hold must last to count as a long press; legal range 2..65535.
REQ-002 Parameter REPEAT_TICKS, default 50, tick periods between auto-repeat pulses while held after a long press; legal range 2..65535.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port b_pulse  input  1  one-cycle debounced press pulse from the upstream button controller.
REQ-006 Port b_hold  input  1  level from the upstream button controller; 1 while the press is latched, 0 once a debounced release is seen.
REQ-007 Port tick  input  1  timebase enable; counters advance only in cycles where tick=1.
REQ-008 Port short_press  output  1  one-cycle pulse: press released before LONG_TICKS.
REQ-009 Port long_press  output  1  one-cycle pulse: hold reached LONG_TICKS.
REQ-010 Port repeat_press  output  1  one-cycle pulse every REPEAT_TICKS while still held after long_press.
REQ-011 Port busy  output  1  1 whenever the FSM is not IDLE.
REQ-012 Port repeat_count  output  8  number of repeat_press pulses in the current hold, saturating at 255.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, PRESSED and REPEAT.
REQ-014 The internal tick counter SHALL be 16 bits, unsigned, and SHALL be cleared on every state entry.
REQ-015 IDLE: b_pulse=1 SHALL move the FSM to PRESSED and clear repeat_count; b_pulse=0 SHALL leave it in IDLE.
REQ-016 PRESSED: b_hold=0 SHALL assert short_press for exactly the next cycle and return the FSM to IDLE.
REQ-017 PRESSED, b_hold=1, tick=1, counter=LONG_TICKS-1: the FSM SHALL assert long_press for the next cycle and move to REPEAT.
REQ-018 PRESSED, b_hold=1, tick=1, counter<LONG_TICKS-1: counter SHALL increment by 1.
REQ-019 REPEAT: b_hold=0 SHALL return the FSM to IDLE with no output pulse.
REQ-020 REPEAT, b_hold=1, tick=1, counter=REPEAT_TICKS-1: the block SHALL assert repeat_press for the next cycle, clear the counter and increment repeat_count (saturating at 255).
REQ-021 REPEAT, b_hold=1, tick=1, counter<REPEAT_TICKS-1: counter SHALL increment by 1.
REQ-022 Latency: every output pulse SHALL appear exactly one clk cycle after the qualifying input sample; all outputs SHALL be registered.
REQ-023 Release and threshold in the same cycle (b_hold=0 and tick=1 at the terminal count): release SHALL win, giving short_press in PRESSED and nothing in REPEAT.
REQ-024 b_pulse in PRESSED or REPEAT SHALL be ignored.
REQ-025 tick=0 SHALL freeze the counter but SHALL NOT block release detection.
REQ-026 At most one of short_press, long_press and repeat_press SHALL be high in any cycle.
REQ-027 busy SHALL equal (state != IDLE), combinationally from the state register.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, counter=0, repeat_count=0, short_press=0, long_press=0 and repeat_press=0, regardless of clk.
REQ-029 Reset asserted mid-hold SHALL suppress all pending pulses.
REQ-030 After rst deasserts, the block SHALL require a fresh b_pulse before leaving IDLE, even if b_hold is still 1.

Verification (LONG_TICKS=4, REPEAT_TICKS=2, tick=1 unless stated)
REQ-031 Short press: b_pulse at cycle 0, b_hold=1 for cycles 0-2, then 0 -> short_press=1 for one cycle at cycle 4; long_press stays 0.
REQ-032 Long press with repeats: b_pulse at cycle 0, b_hold held 12 cycles -> long_press at cycle 5; repeat_press at cycles 7, 9 and 11; repeat_count=3; no pulse on release.
REQ-033 Simultaneous release and terminal count: b_hold falls in the cycle where counter=3 -> short_press=1 and long_press=0.
REQ-034 Tick gating: tick=1 only every 3rd cycle with hold held -> long_press only after 4 ticks; release with tick=0 still yields short_press one cycle later.
REQ-035 Async reset in REPEAT: rst pulsed between clk edges -> all outputs 0 and busy=0 immediately; with b_hold still 1, no output until a new b_pulse arrives.
REQ-036 Saturation: hold long enough for 300 repeat periods -> repeat_count stops at 255 while repeat_press keeps pulsing.

Source files
------------

// File: rtl/classificador_toque_if.sv
// Button-classifier signal bundle: upstream press/hold/tick in, classified pulses out.
interface classificador_toque_if;
    logic       b_pulse;
    logic       b_hold;
    logic       tick;
    logic       short_press;
    logic       long_press;
    logic       repeat_press;
    logic       busy;
    logic [7:0] repeat_count;

    // Stimulus side: drives the button controller signals, observes classification
    modport master (
        output b_pulse,
        output b_hold,
        output tick,
        input  short_press,
        input  long_press,
        input  repeat_press,
        input  busy,
        input  repeat_count
    );

    // Classifier side
    modport slave (
        input  b_pulse,
        input  b_hold,
        input  tick,
        output short_press,
        output long_press,
        output repeat_press,
        output busy,
        output repeat_count
    );
endinterface

// File: rtl/classificador_toque.sv
// Classifies a debounced button hold into short press, long press and auto-repeat pulses.
module classificador_toque #(
    parameter int unsigned LONG_TICKS   = 200,
    parameter int unsigned REPEAT_TICKS = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    classificador_toque_if.slave  bus
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned RC_W  = 8;

    // Terminal counts: the tick that lands on these values completes the period
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [RC_W-1:0]  RC_MAX      = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_e;

    state_e            state_q,        state_d;
    logic [CNT_W-1:0]  cnt_q,          cnt_d;
    logic [RC_W-1:0]   repeat_count_q, repeat_count_d;
    logic              short_press_q,  short_press_d;
    logic              long_press_q,   long_press_d;
    logic              repeat_press_q, repeat_press_d;

    // Next-state and next-output logic; release is tested before the tick so it always wins
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        repeat_count_d = repeat_count_q;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        repeat_press_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.b_pulse) begin
                    state_d        = PRESSED;
                    repeat_count_d = '0;
                end
            end

            PRESSED: begin
                if (!bus.b_hold) begin
                    short_press_d = 1'b1;
                    state_d       = IDLE;
                    cnt_d         = '0;
                end else if (bus.tick) begin
                    if (cnt_q >= LONG_LAST) begin
                        long_press_d = 1'b1;
                        state_d      = REPEAT;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            REPEAT: begin
                if (!bus.b_hold) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.tick) begin
                    if (cnt_q >= REPEAT_LAST) begin
                        repeat_press_d = 1'b1;
                        cnt_d          = '0;
                        if (repeat_count_q != RC_MAX) begin
                            repeat_count_d = repeat_count_q + RC_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset clears everything including pending pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            repeat_count_q <= '0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_press_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            repeat_count_q <= repeat_count_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            repeat_press_q <= repeat_press_d;
        end
    end

    assign bus.short_press  = short_press_q;
    assign bus.long_press   = long_press_q;
    assign bus.repeat_press = repeat_press_q;
    assign bus.repeat_count = repeat_count_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_classificador_toque.sv
// Self-checking bench for classificador_toque: directed scenarios plus randomized holds.
module tb_classificador_toque;

    localparam int unsigned LT = 4;
    localparam int unsigned RT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    classificador_toque_if bus();

    classificador_toque #(
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    // Pulse logs (absolute cycle numbers), written by the compare process only
    int short_q[$];
    int long_q[$];
    int rep_q[$];

    // Reference model: counts ticks held since the press and derives pulses arithmetically
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_rc     = 0;
    bit e_short  = 1'b0;
    bit e_long   = 1'b0;
    bit e_rep    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_t = 0; m_rc = 0;
            e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        end else begin
            e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
            if (!m_active) begin
                if (bus.b_pulse) begin
                    m_active = 1'b1; m_t = 0; m_rc = 0;
                end
            end else if (!bus.b_hold) begin
                if (m_t < int'(LT)) e_short = 1'b1;
                m_active = 1'b0;
            end else if (bus.tick) begin
                m_t = m_t + 1;
                if (m_t == int'(LT)) e_long = 1'b1;
                else if (m_t > int'(LT) && ((m_t - int'(LT)) % int'(RT)) == 0) begin
                    e_rep = 1'b1;
                    if (m_rc < 255) m_rc = m_rc + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model and pulse logging
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                chk("short_press",  int'(bus.short_press),  int'(e_short));
                chk("long_press",   int'(bus.long_press),   int'(e_long));
                chk("repeat_press", int'(bus.repeat_press), int'(e_rep));
                chk("busy",         int'(bus.busy),         int'(m_active));
                chk("repeat_count", int'(bus.repeat_count), m_rc);
                chk("one_hot", int'(bus.short_press) + int'(bus.long_press) + int'(bus.repeat_press) <= 1 ? 1 : 0, 1);
            end
            if (bus.short_press)  short_q.push_back(cyc);
            if (bus.long_press)   long_q.push_back(cyc);
            if (bus.repeat_press) rep_q.push_back(cyc);
        end
    endtask

    task automatic drive(input logic bp, input logic bh, input logic tk);
        bus.b_pulse = bp;
        bus.b_hold  = bh;
        bus.tick    = tk;
        @(negedge clk);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for clk
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, " rst short"},  int'(bus.short_press),  0);
        chk({tag, " rst long"},   int'(bus.long_press),   0);
        chk({tag, " rst repeat"}, int'(bus.repeat_press), 0);
        chk({tag, " rst busy"},   int'(bus.busy),         0);
        chk({tag, " rst count"},  int'(bus.repeat_count), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int base, s0, l0, r0;

    task automatic begin_test();
        base = cyc;
        s0 = short_q.size();
        l0 = long_q.size();
        r0 = rep_q.size();
    endtask

    initial begin
        bit hold;
        int r;
        bus.b_pulse = 1'b0;
        bus.b_hold  = 1'b0;
        bus.tick    = 1'b0;
        fork
            compare_loop();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("init short",  int'(bus.short_press),  0);
        chk("init long",   int'(bus.long_press),   0);
        chk("init repeat", int'(bus.repeat_press), 0);
        chk("init busy",   int'(bus.busy),         0);
        chk("init count",  int'(bus.repeat_count), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) drive(0, 0, 1);

        // Short press: released after 3 held cycles
        begin_test();
        drive(1, 1, 1);
        repeat (2) drive(0, 1, 1);
        drive(0, 0, 1);
        repeat (4) drive(0, 0, 1);
        chk("short: short count", short_q.size() - s0, 1);
        if (short_q.size() > s0) chk("short: short cycle", short_q[s0] - base, 4);
        chk("short: long count", long_q.size() - l0, 0);

        // Long press with three repeats, silent release
        begin_test();
        drive(1, 1, 1);
        repeat (11) drive(0, 1, 1);
        repeat (4) drive(0, 0, 1);
        chk("long: long count", long_q.size() - l0, 1);
        if (long_q.size() > l0) chk("long: long cycle", long_q[l0] - base, 5);
        chk("long: repeat count", rep_q.size() - r0, 3);
        for (int i = 0; i < 3; i++)
            if (rep_q.size() > r0 + i) chk("long: repeat cycle", rep_q[r0 + i] - base, 7 + 2 * i);
        chk("long: short count", short_q.size() - s0, 0);
        chk("long: dut repeat_count", int'(bus.repeat_count), 3);
        chk("long: model repeat_count", m_rc, 3);

        // Release coincides with terminal count: release wins
        begin_test();
        drive(1, 1, 1);
        repeat (3) drive(0, 1, 1);
        drive(0, 0, 1);
        repeat (3) drive(0, 0, 1);
        chk("simul: short count", short_q.size() - s0, 1);
        if (short_q.size() > s0) chk("simul: short cycle", short_q[s0] - base, 5);
        chk("simul: long count", long_q.size() - l0, 0);

        // Tick every third cycle
        begin_test();
        drive(1, 1, 0);
        for (int i = 1; i <= 14; i++) drive(0, 1, logic'(i % 3 == 0));
        drive(0, 0, 0);
        repeat (3) drive(0, 0, 0);
        chk("tick: long count", long_q.size() - l0, 1);
        if (long_q.size() > l0) chk("tick: long cycle", long_q[l0] - base, 13);
        chk("tick: short count", short_q.size() - s0, 0);

        // Release while tick=0
        begin_test();
        drive(1, 1, 0);
        repeat (2) drive(0, 1, 0);
        drive(0, 0, 0);
        repeat (3) drive(0, 0, 0);
        chk("tick0 rel: short count", short_q.size() - s0, 1);
        if (short_q.size() > s0) chk("tick0 rel: short cycle", short_q[s0] - base, 4);

        // Async reset in REPEAT with hold still high
        drive(1, 1, 1);
        repeat (6) drive(0, 1, 1);
        async_reset("repeat");
        begin_test();
        repeat (8) drive(0, 1, 1);
        chk("post-rst: pulses", (short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0), 0);
        chk("post-rst: busy", int'(bus.busy), 0);
        drive(1, 1, 1);
        repeat (3) drive(0, 1, 1);
        drive(0, 0, 1);
        repeat (2) drive(0, 0, 1);
        chk("post-rst: fresh press short", short_q.size() - s0, 1);

        // Saturation: 300 repeat periods
        begin_test();
        drive(1, 1, 1);
        repeat (LT + 300 * RT) drive(0, 1, 1);
        chk("sat: dut repeat_count", int'(bus.repeat_count), 255);
        chk("sat: repeat pulses", rep_q.size() - r0, 300);
        repeat (3) drive(0, 0, 1);
        chk("sat: count held after release", int'(bus.repeat_count), 255);

        // Randomized holds, spurious pulses, gated ticks and occasional resets
        hold = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(99, 0));
            if (!hold && r < 10) begin
                hold = 1'b1;
                drive(1, 1, logic'($urandom_range(2, 0) != 0));
            end else begin
                if (hold && r < 8) hold = 1'b0;
                drive(logic'(r >= 95), hold, logic'($urandom_range(2, 0) != 0));
            end
            if ($urandom_range(399, 0) == 0) async_reset("random");
        end
        repeat (3) drive(0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
